// File: rtl/boot_loader_if.sv
// Host word stream, memory MI/RI write port and status lines of the boot loader.
// The loader uses the slave modport; the host/memory side uses master.
interface boot_loader_if #(parameter int WIDTH = 16) ();
    logic             start;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             rx_ready;
    logic             mem_MI;
    logic             mem_RI;
    logic [WIDTH-1:0] mem_write;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             err;

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, mem_MI, mem_RI, mem_write, cpu_hold, busy, done, err
    );

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, mem_MI, mem_RI, mem_write, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/boot_loader.sv
// Framed program loader: {addr, len, data...} stream -> memory MI/RI write port.
// Optional trailing checksum word when BOOT_LOADER_CHECKSUM_EN is defined.
module boot_loader #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    boot_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_LEN, WAIT_DATA, SET_MAR, WRITE,
`ifdef BOOT_LOADER_CHECKSUM_EN
        GET_SUM,
`endif
        DONE
    } state_t;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t LAST = GET_SUM;
`else
    localparam state_t LAST = DONE;
`endif

    state_t           state, state_nx;
    logic [WIDTH-1:0] addr, count, data;
    logic             err_q;
    logic             rx_ready, mem_mi, mem_ri, cpu_hold, busy, done;
    logic [WIDTH-1:0] mem_write;
    logic             xfer;

    assign xfer = bus.rx_valid & rx_ready;

    // All outputs decode registered state only; rx_valid steers next state alone.
    always_comb begin
        state_nx  = state;
        rx_ready  = 1'b0;
        mem_mi    = 1'b0;
        mem_ri    = 1'b0;
        mem_write = '0;
        cpu_hold  = 1'b1;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) state_nx = GET_ADDR;
            end
            GET_ADDR: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) state_nx = GET_LEN;
            end
            GET_LEN: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) state_nx = (bus.rx_data == '0) ? LAST : WAIT_DATA;
            end
            WAIT_DATA: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) state_nx = SET_MAR;
            end
            SET_MAR: begin
                mem_mi    = 1'b1;
                mem_write = addr;
                state_nx  = WRITE;
            end
            WRITE: begin
                mem_ri    = 1'b1;
                mem_write = data;
                state_nx  = (count == WIDTH'(1)) ? LAST : WAIT_DATA;
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            GET_SUM: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) state_nx = DONE;
            end
`endif
            DONE: begin
                busy     = 1'b0;
                done     = ~err_q;
                cpu_hold = err_q;
                if (bus.start) state_nx = GET_ADDR;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            count <= '0;
            data  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                GET_ADDR:  if (xfer) addr  <= bus.rx_data;
                GET_LEN:   if (xfer) count <= bus.rx_data;
                WAIT_DATA: if (xfer) data  <= bus.rx_data;
                WRITE: begin
                    addr  <= addr + WIDTH'(1);
                    count <= count - WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum;

    // Running sum of every frame word; the checksum word must bring it to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) err_q <= 1'b0;
                GET_ADDR:   if (xfer) sum <= bus.rx_data;
                GET_LEN, WAIT_DATA: if (xfer) sum <= sum + bus.rx_data;
                GET_SUM:    if (xfer) err_q <= ((sum + bus.rx_data) != '0);
                default: ;
            endcase
        end
    end
`else
    assign err_q = 1'b0;
`endif

    assign bus.rx_ready  = rx_ready;
    assign bus.mem_MI    = mem_mi;
    assign bus.mem_RI    = mem_ri;
    assign bus.mem_write = mem_write;
    assign bus.cpu_hold  = cpu_hold;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader (WIDTH=8): frame table, write scoreboard, corner sequences.
`timescale 1ns/1ps
module tb_boot_loader;
    localparam int W = 8;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct packed {
        logic [W-1:0]        a;
        logic [W-1:0]        n;
        logic [3:0][W-1:0]   d;
        logic [7:0]          exp_lat;
    } frame_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    boot_loader_if #(.WIDTH(W)) bus ();
    boot_loader #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mi_cnt = 0;
    int ri_cnt = 0;
    wr_t exp_q[$];
    logic [W-1:0] mar;
    logic [W-1:0] ram [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model plus write scoreboard and per-cycle port invariants.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_MI || bus.mem_RI) begin
            chk("mi_ri_exclusive", {31'b0, bus.mem_MI & bus.mem_RI}, 0);
            chk("ready_in_mem_state", {31'b0, bus.rx_ready}, 0);
        end
        if (bus.mem_MI) begin
            mar <= bus.mem_write;
            mi_cnt++;
        end
        if (bus.mem_RI) begin
            wr_t e;
            ram[mar] <= bus.mem_write;
            ri_cnt++;
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("wr_addr", {24'b0, mar}, {24'b0, e.a});
                chk("wr_data", {24'b0, bus.mem_write}, {24'b0, e.d});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w, input bit stall);
        int t;
        if (stall) begin
            bus.rx_valid = 1'b0;
            step();
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = w;
        for (t = 0; t < 20 && !bus.rx_ready; t++) step();
        if (!bus.rx_ready) chk("ready_timeout", 0, 1);
        step();
        if (stall) bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start(output int s_cyc);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_end(input int s_cyc, output int lat);
        int t;
        for (t = 0; t < 60 && !(bus.done || bus.err); t++) step();
        if (!(bus.done || bus.err)) chk("done_timeout", 0, 1);
        lat = cyc - s_cyc + 1;
    endtask

    task automatic run_frame(input frame_t f, input bit stall, input bit bad_sum, output int lat);
        int s_cyc;
        logic [W-1:0] sum;
        logic [W-1:0] s;
        pulse_start(s_cyc);
        sum = f.a + f.n;
        send(f.a, stall);
        send(f.n, stall);
        for (int i = 0; i < int'(f.n); i++) begin
            exp_q.push_back('{a: f.a + W'(i), d: f.d[i]});
            sum = sum + f.d[i];
            send(f.d[i], stall);
        end
        s = bad_sum ? '0 : (W'(0) - sum);
        if (CS != 0) send(s, stall);
        bus.rx_valid = 1'b0;
        wait_end(s_cyc, lat);
    endtask

    task automatic check_mem(input frame_t f, input string tag);
        logic [W-1:0] ad;
        for (int i = 0; i < int'(f.n); i++) begin
            ad = f.a + W'(i);
            chk({tag, "_ram"}, {24'b0, ram[ad]}, {24'b0, f.d[i]});
        end
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, {31'b0, bus.done}, 1);
        chk({tag, "_err"}, {31'b0, bus.err}, 0);
        chk({tag, "_hold"}, {31'b0, bus.cpu_hold}, 0);
        chk({tag, "_busy"}, {31'b0, bus.busy}, 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rx_ready"}, {31'b0, bus.rx_ready}, 0);
        chk({tag, "_mi_ri"}, {30'b0, bus.mem_MI, bus.mem_RI}, 0);
        chk({tag, "_mem_write"}, {24'b0, bus.mem_write}, 0);
        chk({tag, "_hold"}, {31'b0, bus.cpu_hold}, 1);
        chk({tag, "_busy_done_err"}, {29'b0, bus.busy, bus.done, bus.err}, 0);
    endtask

    frame_t vec [4];
    frame_t f;
    int lat, mi0, ri0;

    initial begin
        vec[0] = '{a: 8'd100, n: 8'd3, d: {8'h00, 8'h33, 8'h22, 8'h11}, exp_lat: 8'(12 + CS)};
        vec[1] = '{a: 8'd255, n: 8'd2, d: {8'h00, 8'h00, 8'hBB, 8'hAA}, exp_lat: 8'(9 + CS)};
        vec[2] = '{a: 8'h10,  n: 8'd0, d: {8'h00, 8'h00, 8'h00, 8'h00}, exp_lat: 8'(3 + CS)};
        vec[3] = '{a: 8'h40,  n: 8'd4, d: {8'h04, 8'h03, 8'h02, 8'h01}, exp_lat: 8'(15 + CS)};

        bus.start = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h55;
        reset = 1'b1;
        step();
        check_idle("reset1");
        step();
        check_idle("reset2");
        reset = 1'b0;
        bus.start = 1'b0;
        bus.rx_valid = 1'b0;
        chk("reset_no_writes", ri_cnt + mi_cnt, 0);
        step();
        check_idle("idle_hold");

        for (int i = 0; i < 4; i++) begin
            mi0 = mi_cnt;
            run_frame(vec[i], 1'b0, 1'b0, lat);
            chk($sformatf("vec%0d_latency", i), lat, {24'b0, vec[i].exp_lat});
            check_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_mi_pulses", i), mi_cnt - mi0, {24'b0, vec[i].n});
            check_mem(vec[i], $sformatf("vec%0d", i));
        end

        // Same basic frame with rx_valid dropping between every word.
        f = vec[0];
        f.a = 8'h80;
        run_frame(f, 1'b1, 1'b0, lat);
        check_done("stall");
        check_mem(f, "stall");

        // Reset while sitting in SET_MAR of word 2: that word never reaches WRITE.
        f = '{a: 8'h20, n: 8'd3, d: {8'h00, 8'h5C, 8'h5B, 8'h5A}, exp_lat: 8'd0};
        ri0 = ri_cnt;
        pulse_start(lat);
        send(f.a, 1'b0);
        send(f.n, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) exp_q.push_back('{a: f.a + W'(i), d: f.d[i]});
            send(f.d[i], 1'b0);
        end
        bus.rx_valid = 1'b0;
        chk("midreset_in_set_mar", {31'b0, bus.mem_MI}, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("midreset");
        step();
        chk("midreset_writes", ri_cnt - ri0, 2);
        chk("midreset_sb_empty", exp_q.size(), 0);
        f = '{a: 8'h30, n: 8'd2, d: {8'h00, 8'h00, 8'h77, 8'h66}, exp_lat: 8'd0};
        run_frame(f, 1'b0, 1'b0, lat);
        check_done("after_reset");
        check_mem(f, "after_reset");

`ifdef BOOT_LOADER_CHECKSUM_EN
        run_frame(vec[0], 1'b0, 1'b1, lat);
        chk("badsum_err", {31'b0, bus.err}, 1);
        chk("badsum_done", {31'b0, bus.done}, 0);
        chk("badsum_hold", {31'b0, bus.cpu_hold}, 1);
        chk("badsum_busy", {31'b0, bus.busy}, 0);
        step();
        chk("badsum_err_sticky", {31'b0, bus.err}, 1);
        run_frame(vec[0], 1'b0, 1'b0, lat);
        check_done("goodsum");
`else
        chk("err_tied_low", {31'b0, bus.err}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
